// File: rtl/cis_line_capture.sv
// CIS line capture: skips the sensor's dummy lead-in samples after each
// line-start pulse, tags every pixel with colour and first-pixel flag,
// and packs pixel pairs into 32-bit words for the downstream pixel FIFO.
// Lines that arrive while the FIFO is almost full are dropped and counted.
// Lines cut short by a new line-start are aborted and counted.
module cis_line_capture #(
    parameter int DUMMY_PIXELS = 89,
    parameter int LINE_PIXELS  = 2592,
    parameter bit ADC_INV_MSB  = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        LINE_START,
    input  logic [1:0]  COLOR,
    input  logic [11:0] ADC_DATA,
    input  logic        FIFO_AFULL,
    output logic [31:0] PIXELS,
    output logic        PIXELS_DV,
    output logic        LINE_DONE,
    output logic        BUSY,
    output logic [15:0] DROP_CNT,
    output logic [15:0] ABORT_CNT
);

    // Odd line lengths would leave a dangling half word at the end of every line.
    if ((LINE_PIXELS % 2) != 0) begin : g_odd_line_pixels
        $error("cis_line_capture: LINE_PIXELS must be even");
    end

    localparam int SKIP_W = (DUMMY_PIXELS > 0) ? $clog2(DUMMY_PIXELS + 1) : 1;
    localparam int PIX_W  = 12;

    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((DUMMY_PIXELS > 0) ? (DUMMY_PIXELS - 1) : 0);
    localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIXELS - 1);
    localparam logic [11:0]       INV_MASK  = ADC_INV_MSB ? 12'h800 : 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // With no dummy samples the line goes straight to capture.
    localparam state_t START_STATE = (DUMMY_PIXELS == 0) ? ST_CAPTURE : ST_SKIP;

    // Saturating 16-bit increment for the event counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [SKIP_W-1:0]  skip_cnt_r;
    logic [PIX_W-1:0]   pix_cnt_r;
    logic [1:0]         color_r;
    logic [15:0]        even_pix_r;
    logic [31:0]        pixels_r;
    logic               pixels_dv_r;
    logic               line_done_r;
    logic               busy_r;
    logic [15:0]        drop_cnt_r;
    logic [15:0]        abort_cnt_r;

    logic               start_s;
    logic               accept_s;
    logic               drop_s;
    logic               abort_s;
    logic               take_s;
    logic               last_s;
    logic [15:0]        pixel_s;

    // Current sample formatted as a tagged 16-bit pixel.
    always_comb begin
        pixel_s = {color_r, (pix_cnt_r == 12'd0), 1'b0, ADC_DATA ^ INV_MASK};
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        start_s     = LINE_START & ENABLE;
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        drop_s      = 1'b0;
        abort_s     = 1'b0;
        take_s      = 1'b0;
        last_s      = 1'b0;
        if (start_s) begin
            // A line-start always wins; an unfinished line is abandoned.
            abort_s = (state_r != ST_IDLE);
            if (FIFO_AFULL) begin
                drop_s      = 1'b1;
                state_nxt_s = ST_IDLE;
            end else begin
                accept_s    = 1'b1;
                state_nxt_s = START_STATE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_SKIP: begin
                    if (skip_cnt_r == SKIP_LAST) begin
                        state_nxt_s = ST_CAPTURE;
                    end else begin
                        state_nxt_s = ST_SKIP;
                    end
                end
                ST_CAPTURE: begin
                    take_s = 1'b1;
                    if (pix_cnt_r == PIX_LAST) begin
                        last_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Line bookkeeping: latched colour, dummy-sample and pixel counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            color_r    <= 2'd0;
            skip_cnt_r <= '0;
            pix_cnt_r  <= 12'd0;
        end else if (accept_s) begin
            color_r    <= COLOR;
            skip_cnt_r <= '0;
            pix_cnt_r  <= 12'd0;
        end else begin
            if (state_r == ST_SKIP) begin
                skip_cnt_r <= skip_cnt_r + SKIP_ONE;
            end
            if (take_s) begin
                pix_cnt_r <= pix_cnt_r + 12'd1;
            end
        end
    end

    // Pair packing: hold the even pixel, emit the word when the odd one arrives.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            even_pix_r  <= 16'd0;
            pixels_r    <= 32'd0;
            pixels_dv_r <= 1'b0;
            line_done_r <= 1'b0;
        end else begin
            pixels_dv_r <= 1'b0;
            line_done_r <= 1'b0;
            if (take_s) begin
                if (pix_cnt_r[0] == 1'b0) begin
                    even_pix_r <= pixel_s;
                end else begin
                    pixels_r    <= {even_pix_r, pixel_s};
                    pixels_dv_r <= 1'b1;
                    line_done_r <= last_s;
                end
            end
        end
    end

    // Status: busy flag and saturating drop/abort counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_r      <= 1'b0;
            drop_cnt_r  <= 16'd0;
            abort_cnt_r <= 16'd0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            if (drop_s) begin
                drop_cnt_r <= sat_inc16(drop_cnt_r);
            end
            if (abort_s) begin
                abort_cnt_r <= sat_inc16(abort_cnt_r);
            end
        end
    end

    assign PIXELS    = pixels_r;
    assign PIXELS_DV = pixels_dv_r;
    assign LINE_DONE = line_done_r;
    assign BUSY      = busy_r;
    assign DROP_CNT  = drop_cnt_r;
    assign ABORT_CNT = abort_cnt_r;

endmodule
